ifetch_prefetch: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the single-cycle core datapath. It replaces the core's direct PC-to-instruction-memory read.
- Issues sequential word-fetch requests to instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers fetched instructions, each paired with its PC, in a small FIFO that the core pops with a valid/ready handshake.
- The core's taken branches and jumps (PCSel=1) arrive as a redirect. A redirect flushes the buffer and discards all stale in-flight responses.

---
 rtl/ifetch_prefetch_if.sv | 13 +
 rtl/ifetch_prefetch.sv | 75 +++++++
 tb/tb_ifetch_prefetch.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ifetch_prefetch_if.sv
// ifetch_prefetch_if: memory request/response, redirect and instruction-delivery signals of the fetch front end
interface ifetch_prefetch_if #(parameter int WIDTH = 32);
  logic             mem_req_valid, mem_req_ready, mem_resp_valid, redirect_valid, instr_valid, instr_ready;
  logic [WIDTH-1:0] mem_req_addr, mem_resp_data, redirect_pc, instr, instr_pc;
  modport master(
    output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, redirect_valid, redirect_pc, instr_ready
  );
  modport slave(
    input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
    output mem_req_ready, mem_resp_valid, mem_resp_data, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: sequential instruction prefetcher with a PC-tagged FIFO and redirect flush
module ifetch_prefetch #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               rst,
  ifetch_prefetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t             state, state_n;
  logic [WIDTH-1:0]   fetch_pc, resp_pc, redir_pc;
  logic [CW-1:0]      outstanding, drop_cnt, fifo_count, drop_new;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [2*WIDTH-1:0] fifo [DEPTH];
  logic               credit, req_fire, push, pop, redir, resp, drop_done;
  assign redir     = bus.redirect_valid;
  assign resp      = bus.mem_resp_valid;
  assign redir_pc  = bus.redirect_pc & ~WIDTH'(3);
  assign credit    = {1'b0, fifo_count} + {1'b0, outstanding} < (CW+1)'(DEPTH);
  assign req_fire  = bus.mem_req_valid & bus.mem_req_ready;
  assign push      = resp & (drop_cnt == '0) & !redir;
  assign pop       = bus.instr_valid & bus.instr_ready & !redir;
  // a response arriving alongside the redirect belongs to the old path
  assign drop_new  = outstanding - CW'(resp);
  assign drop_done = (drop_cnt == '0) || (drop_cnt == CW'(1) && resp);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? FETCH :
              redir ? (drop_new != '0 ? DRAIN : FETCH) :
              (state == DRAIN && drop_done) ? FETCH : state;
  end
  always_comb begin
    bus.mem_req_valid          = !rst && state != IDLE && credit && !redir;
    bus.mem_req_addr           = rst ? RESET_PC : fetch_pc;
    bus.instr_valid            = !rst && fifo_count != '0;
    {bus.instr, bus.instr_pc}  = fifo[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(resp);
      if (redir) begin
        fetch_pc   <= redir_pc;
        resp_pc    <= redir_pc;
        drop_cnt   <= drop_new;
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + WIDTH'(4);
        if (resp && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        if (push) resp_pc <= resp_pc + WIDTH'(4);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= {bus.mem_resp_data, resp_pc};
  always_ff @(posedge clk)
    if (!rst) assert (!(resp && fifo_count == CW'(DEPTH)));
endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb_ifetch_prefetch: directed checks of the prefetcher against a latency-programmable memory model
module tb_ifetch_prefetch;
  logic clk = 0, rst = 1, rst_w = 1;
  always #5 clk = ~clk;
  ifetch_prefetch_if #(.WIDTH(32)) bus();
  ifetch_prefetch_if #(.WIDTH(32)) bw();
  ifetch_prefetch #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus));
  ifetch_prefetch #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (.clk(clk), .rst(rst_w), .bus(bw));
  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t        q[$];
  logic [31:0] pops[$], pops_i[$], reqs[$], pops_w[$];
  logic [31:0] pend_d;
  logic        pend_v = 0;
  int          n_chk = 0, n_fail = 0, lat = 1, cyc = 0;
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC3A5_0000;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    step(2);
    rst = 0;
    pops.delete();
    pops_i.delete();
    reqs.delete();
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  // responses are staged at the negedge for the following rising edge
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      bus.mem_resp_valid = 0;
      bus.mem_resp_data  = 0;
    end else begin
      if (q.size() > 0 && q[0].due <= cyc + 1) begin
        bus.mem_resp_valid = 1;
        bus.mem_resp_data  = instr_of(q[0].addr);
        void'(q.pop_front());
      end else
        bus.mem_resp_valid = 0;
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        q.push_back('{bus.mem_req_addr, cyc + 1 + lat});
        reqs.push_back(bus.mem_req_addr);
      end
      if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
        pops.push_back(bus.instr_pc);
        pops_i.push_back(bus.instr);
      end
    end
  end
  always @(negedge clk) begin
    bw.mem_resp_valid = pend_v && !rst_w;
    bw.mem_resp_data  = pend_d;
    pend_v = bw.mem_req_valid && bw.mem_req_ready && !rst_w;
    pend_d = instr_of(bw.mem_req_addr);
    if (!rst_w && bw.instr_valid && bw.instr_ready) pops_w.push_back(bw.instr_pc);
  end
  initial begin
    bus.mem_req_ready = 1; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.instr_ready = 1;
    bw.mem_req_ready = 1; bw.redirect_valid = 0; bw.redirect_pc = 0; bw.instr_ready = 1;
    step(2);
    chk("rst_req_valid", bus.mem_req_valid, 0);
    chk("rst_instr_valid", bus.instr_valid, 0);
    chk("rst_req_addr", bus.mem_req_addr, 32'h0);
    chk("rst_w_req_addr", bw.mem_req_addr, 32'hFFFF_FFF8);
    lat = 1;
    do_reset();
    chk("t1_idle_no_req", bus.mem_req_valid, 0);
    step(1);
    chk("t1_first_req_valid", bus.mem_req_valid, 1);
    chk("t1_first_req_addr", bus.mem_req_addr, 32'h0);
    step(1);
    chk("t1_not_yet_valid", bus.instr_valid, 0);
    step(1);
    chk("t1_lat_valid", bus.instr_valid, 1);
    chk("t1_first_pc", bus.instr_pc, 32'h0);
    chk("t1_first_instr", bus.instr, instr_of(32'h0));
    step(8);
    chk("t1_pop_count", pops.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_pc", pops[i], 32'(4 * i));
      chk("t1_instr", pops_i[i], instr_of(32'(4 * i)));
    end
    bus.instr_ready = 0;
    do_reset();
    step(10);
    chk("t2_req_count", reqs.size(), 4);
    chk("t2_last_req", reqs[3], 32'hC);
    chk("t2_req_stall", bus.mem_req_valid, 0);
    chk("t2_fifo_full", dut.fifo_count, 4);
    bus.instr_ready = 1;
    step(1);
    bus.instr_ready = 0;
    chk("t2_one_pop", pops.size(), 1);
    chk("t2_pop_pc", pops[0], 32'h0);
    chk("t2_new_req_valid", bus.mem_req_valid, 1);
    chk("t2_new_req_addr", bus.mem_req_addr, 32'h10);
    step(4);
    chk("t2_req_count2", reqs.size(), 5);
    chk("t2_restall", bus.mem_req_valid, 0);
    lat = 4;
    bus.instr_ready = 1;
    do_reset();
    step(4);
    chk("t3_pre_outstanding", dut.outstanding, 3);
    chk("t3_pre_no_resp", bus.mem_resp_valid, 0);
    bus.redirect_valid = 1;
    bus.redirect_pc = 32'h100;
    pops.delete();
    pops_i.delete();
    #1;
    chk("t3_no_req_in_redirect", bus.mem_req_valid, 0);
    step(1);
    bus.redirect_valid = 0;
    #1;
    chk("t3_fifo_empty", dut.fifo_count, 0);
    chk("t3_drop_cnt", dut.drop_cnt, 3);
    chk("t3_req_valid", bus.mem_req_valid, 1);
    chk("t3_req_addr", bus.mem_req_addr, 32'h100);
    step(14);
    chk("t3_enough_pops", 32'(pops.size() >= 3), 1);
    for (int i = 0; i < pops.size(); i++) begin
      chk("t3_pc", pops[i], 32'h100 + 32'(4 * i));
      chk("t3_instr", pops_i[i], instr_of(32'h100 + 32'(4 * i)));
    end
    chk("t3_drop_done", dut.drop_cnt, 0);
    lat = 2;
    do_reset();
    step(4);
    bus.redirect_valid = 1;
    bus.redirect_pc = 32'h203;
    pops.delete();
    pops_i.delete();
    @(negedge clk);
    #1;
    chk("t4_pre_outstanding", dut.outstanding, 2);
    chk("t4_pre_resp", bus.mem_resp_valid, 1);
    chk("t4_pre_pop", bus.instr_valid, 1);
    step(1);
    bus.redirect_valid = 0;
    #1;
    chk("t4_fifo_empty", dut.fifo_count, 0);
    chk("t4_instr_valid", bus.instr_valid, 0);
    chk("t4_drop_cnt", dut.drop_cnt, 1);
    chk("t4_req_valid", bus.mem_req_valid, 1);
    chk("t4_req_addr", bus.mem_req_addr, 32'h200);
    step(10);
    chk("t4_first_pc", pops[0], 32'h200);
    chk("t4_first_instr", pops_i[0], instr_of(32'h200));
    lat = 3;
    do_reset();
    step(5);
    bus.redirect_valid = 1;
    bus.redirect_pc = 32'h40;
    pops.delete();
    pops_i.delete();
    step(1);
    bus.redirect_pc = 32'h80;
    step(1);
    bus.redirect_valid = 0;
    step(16);
    chk("t5_enough_pops", 32'(pops.size() >= 4), 1);
    for (int i = 0; i < pops.size(); i++) begin
      chk("t5_pc", pops[i], 32'h80 + 32'(4 * i));
      chk("t5_instr", pops_i[i], instr_of(32'h80 + 32'(4 * i)));
    end
    rst_w = 0;
    pops_w.delete();
    step(7);
    chk("t6_pop_count", 32'(pops_w.size() >= 3), 1);
    chk("t6_pc0", pops_w[0], 32'hFFFF_FFF8);
    chk("t6_pc1", pops_w[1], 32'hFFFF_FFFC);
    chk("t6_pc2", pops_w[2], 32'h0000_0000);
    rst_w = 1;
    step(1);
    chk("t6_rst_req_valid", bw.mem_req_valid, 0);
    chk("t6_rst_instr_valid", bw.instr_valid, 0);
    chk("t6_rst_req_addr", bw.mem_req_addr, 32'hFFFF_FFF8);
    chk("t6_rst_fifo_count", dut_w.fifo_count, 0);
    chk("t6_rst_outstanding", dut_w.outstanding, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
